// File: rtl/density_dump.sv
// rtl/density_dump.sv - windowed ones-count of a comparator bit, queued and streamed over 8N1 UART
module density_dump #(
    parameter int WIN_LOG2        = 11,
    parameter int CLK_DIV         = 52,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sig,
    input  logic                enable,
    output logic                tx,
    output logic                busy,
    output logic                overflow,
    output logic                sample_valid,
    output logic [WIN_LOG2:0]   sample
);
    localparam int CW    = WIN_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int DIVW  = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic                      s_meta, s_sig;
    logic [WIN_LOG2-1:0]       period;
    logic [CW-1:0]             acc;
    logic                      win_end;
    logic [CW-1:0]             win_count;

    logic [CW-1:0]             mem [DEPTH];
    logic [FIFO_DEPTH_LOG2:0]  wr_ptr, rd_ptr;
    logic                      fifo_empty, fifo_full, push, pop;
    logic [CW-1:0]             fifo_rd;
    logic [13:0]               s14;

    state_t                    state, state_n;
    logic [DIVW-1:0]           div_cnt;
    logic                      bit_done;
    logic [2:0]                bit_idx;
    logic                      pend;
    logic [7:0]                shreg, lo_byte;
    logic                      tx_c;

    assign win_end   = enable && (period == '1);
    assign win_count = acc + {{WIN_LOG2{1'b0}}, s_sig};

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                        (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);
    assign pop       = (state == S_IDLE) && !fifo_empty;
    // A simultaneous pop frees the slot, so a push on a full FIFO still lands.
    assign push      = win_end && (!fifo_full || pop);
    assign fifo_rd   = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
    assign s14       = {{(14-CW){1'b0}}, fifo_rd};

    assign bit_done  = (div_cnt == DIVW'(CLK_DIV - 1));
    assign busy      = !fifo_empty || (state != S_IDLE);
    assign tx        = tx_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_meta       <= 1'b0;
            s_sig        <= 1'b0;
            period       <= '0;
            acc          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overflow     <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            s_meta       <= sig;
            s_sig        <= s_meta;
            sample_valid <= win_end;
            if (!enable) begin
                period <= '0;
                acc    <= '0;
            end else begin
                period <= period + 1'b1;
                acc    <= win_end ? '0 : win_count;
            end
            if (win_end) begin
                sample <= win_count;
                if (fifo_full && !pop)
                    overflow <= 1'b1;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= win_count;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        tx_c    = 1'b1;
        case (state)
            S_IDLE:  if (!fifo_empty) state_n = S_START;
            S_START: begin
                tx_c = 1'b0;
                if (bit_done) state_n = S_DATA;
            end
            S_DATA: begin
                tx_c = shreg[0];
                if (bit_done && bit_idx == 3'd7) state_n = S_STOP;
            end
            S_STOP:  if (bit_done) state_n = pend ? S_START : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Byte0 carries the high half with bit7 set; byte1 follows unconditionally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            bit_idx <= '0;
            pend    <= 1'b0;
            shreg   <= '0;
            lo_byte <= '0;
        end else if (state == S_IDLE) begin
            div_cnt <= '0;
            bit_idx <= '0;
            if (pop) begin
                shreg   <= {1'b1, s14[13:7]};
                lo_byte <= {1'b0, s14[6:0]};
                pend    <= 1'b1;
            end
        end else begin
            div_cnt <= bit_done ? '0 : div_cnt + 1'b1;
            if (state == S_DATA && bit_done) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == S_STOP && bit_done && pend) begin
                shreg <= lo_byte;
                pend  <= 1'b0;
            end
        end
    end
endmodule
